sram_access_arbiter: RTL and testbench

Owns the external 1M×16 async SRAM and shares it between two requesters: the recorder, which writes, and the DSP playback path, which reads. It serialises their accesses, generates the SRAM strobe timing and the tri-state DQ control, and tracks the recorded length for playback stop detection. It sits between the recorder/DSP blocks and the top-level SRAM pins, and replaces direct pin muxing in the top.

---
 rtl/audio_mem_pkg.sv | 25 ++
 rtl/sram_access_arbiter_if.sv | 29 ++
 rtl/sram_dq_pad.sv | 30 +++
 rtl/sram_access_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_mem_pkg.sv
// Shared types and constants for the SRAM access arbiter slice.
//   SRAM_AW / SRAM_DW : external SRAM geometry (1M x 16)
//   arb_state_t       : arbiter FSM state encoding
//   sram_req_t        : latched access (req = write in flight, addr, data)
package audio_mem_pkg;

    localparam int unsigned SRAM_AW = 20;
    localparam int unsigned SRAM_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_WAIT,
        ST_RD_DONE
    } arb_state_t;

    // req doubles as the DQ drive enable: set only while a write owns the bus.
    typedef struct packed {
        logic               req;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] data;
    } sram_req_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side handshake bundle for sram_access_arbiter.
//   wr_req/wr_addr/wr_data -> wr_ack   : recorder write channel
//   rd_req/rd_addr         -> rd_ack, rd_data : playback read channel
// master = requester side, slave = arbiter side.
interface sram_access_arbiter_if
    import audio_mem_pkg::*;
#(
    parameter int unsigned AW = SRAM_AW,
    parameter int unsigned DW = SRAM_DW
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_ack, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_ack, rd_data
    );
endinterface

// File: rtl/sram_dq_pad.sv
// SRAM DQ pad: tri-state output buffer plus the read-data capture register.
//   i_clk, i_rst_n : clock, async active-low reset
//   oe             : drive dq with out_data when high, else high-Z
//   out_data       : write data to place on the bus
//   capture        : load dq into rd_data on the next clock edge
//   rd_data        : last captured word (0 after reset)
//   dq             : bidirectional SRAM data bus
module sram_dq_pad #(
    parameter int unsigned DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          oe,
    input  logic [DW-1:0] out_data,
    input  logic          capture,
    output logic [DW-1:0] rd_data,
    inout  wire  [DW-1:0] dq
);

    assign dq = oe ? out_data : 'z;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data <= '0;
        end else if (capture) begin
            rd_data <= dq;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Arbitrates the external async SRAM between the recorder (writes) and the
// playback path (reads), generates strobe timing, controls DQ direction and
// tracks the recorded length.
//   i_clk, i_rst_n   : clock, async active-low reset
//   bus (slave)      : write/read request-ack channels, o_rd_data equivalent
//   i_clr            : clear o_end_addr / o_full
//   o_end_addr       : highest written address + 1 (saturating)
//   o_full           : top address has been written
//   o_busy           : FSM not idle
//   o_SRAM_* / io_SRAM_DQ : SRAM pins, all outputs registered
module sram_access_arbiter #(
    parameter int unsigned SRAM_AW       = 20,
    parameter int unsigned SRAM_DW       = 16,
    parameter int unsigned WR_CYCLES     = 2,
    parameter int unsigned RD_CYCLES     = 2,
    parameter int unsigned MAX_WR_STREAK = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sram_access_arbiter_if.slave bus,
    input  logic                 i_clr,
    output logic [SRAM_AW-1:0]   o_end_addr,
    output logic                 o_full,
    output logic                 o_busy,
    output logic [SRAM_AW-1:0]   o_SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]   io_SRAM_DQ,
    output logic                 o_SRAM_WE_N,
    output logic                 o_SRAM_CE_N,
    output logic                 o_SRAM_OE_N,
    output logic                 o_SRAM_LB_N,
    output logic                 o_SRAM_UB_N
);
    import audio_mem_pkg::*;

    localparam int unsigned MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned SW      = $clog2(MAX_WR_STREAK + 1);

    arb_state_t         state;
    logic [CW-1:0]      cnt;
    logic [SW-1:0]      streak;
    sram_req_t          cur;
    logic               ce_n;
    logic               we_n;
    logic               oe_n;
    logic               wr_ack;
    logic               rd_ack;
    logic               wr_last;
    logic               rd_last;
    logic               read_wins;
    logic [SRAM_AW-1:0] addr_inc;

    assign wr_last   = (cnt == CW'(WR_CYCLES - 1));
    assign rd_last   = (cnt == CW'(RD_CYCLES - 1));
    // A write is starved out only when a read is waiting and the streak is used up.
    assign read_wins = bus.rd_req && (streak == SW'(MAX_WR_STREAK));
    assign addr_inc  = cur.addr + SRAM_AW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            streak     <= '0;
            cur        <= '0;
            ce_n       <= 1'b1;
            we_n       <= 1'b1;
            oe_n       <= 1'b1;
            wr_ack     <= 1'b0;
            rd_ack     <= 1'b0;
            o_busy     <= 1'b0;
            o_end_addr <= '0;
            o_full     <= 1'b0;
        end else begin
            wr_ack <= 1'b0;
            rd_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.wr_req && !read_wins) begin
                        cur    <= '{req: 1'b1, addr: bus.wr_addr, data: bus.wr_data};
                        streak <= bus.rd_req ? streak + SW'(1) : '0;
                        cnt    <= '0;
                        ce_n   <= 1'b0;
                        we_n   <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= ST_WR_PULSE;
                    end else if (bus.rd_req) begin
                        cur.req  <= 1'b0;
                        cur.addr <= bus.rd_addr;
                        streak   <= '0;
                        cnt      <= '0;
                        ce_n     <= 1'b0;
                        oe_n     <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= ST_RD_WAIT;
                    end
                end

                ST_WR_PULSE: begin
                    if (wr_last) begin
                        we_n   <= 1'b1;
                        wr_ack <= 1'b1;
                        state  <= ST_WR_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_WR_HOLD: begin
                    cur.req <= 1'b0;
                    ce_n    <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= ST_IDLE;
                end

                ST_RD_WAIT: begin
                    if (rd_last) begin
                        oe_n   <= 1'b1;
                        rd_ack <= 1'b1;
                        state  <= ST_RD_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_RD_DONE: begin
                    ce_n   <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    cur.req <= 1'b0;
                    ce_n    <= 1'b1;
                    we_n    <= 1'b1;
                    oe_n    <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase

            // Length is committed in the ack cycle so a coincident clear takes priority.
            if (i_clr) begin
                o_end_addr <= '0;
                o_full     <= 1'b0;
            end else if (state == ST_WR_HOLD) begin
                if (&cur.addr) begin
                    o_full     <= 1'b1;
                    o_end_addr <= '1;
                end else if (addr_inc > o_end_addr) begin
                    o_end_addr <= addr_inc;
                end
            end
        end
    end

    sram_dq_pad #(
        .DW (SRAM_DW)
    ) u_dq_pad (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .oe       (cur.req),
        .out_data (cur.data),
        .capture  (state == ST_RD_WAIT && rd_last),
        .rd_data  (bus.rd_data),
        .dq       (io_SRAM_DQ)
    );

    assign bus.wr_ack  = wr_ack;
    assign bus.rd_ack  = rd_ack;
    assign o_SRAM_ADDR = cur.addr;
    assign o_SRAM_CE_N = ce_n;
    assign o_SRAM_WE_N = we_n;
    assign o_SRAM_OE_N = oe_n;
    assign o_SRAM_LB_N = ce_n;
    assign o_SRAM_UB_N = ce_n;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a small behavioural SRAM model.
module tb_sram_access_arbiter;

    localparam logic [15:0] PROBE = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        probe_en = 1'b0;
    logic [19:0] end_addr;
    logic        full;
    logic        busy;
    logic [19:0] sram_addr;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;
    wire  [15:0] dq;
    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    sram_access_arbiter_if bus ();

    sram_access_arbiter #(
        .SRAM_AW       (20),
        .SRAM_DW       (16),
        .WR_CYCLES     (2),
        .RD_CYCLES     (2),
        .MAX_WR_STREAK (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .i_clr       (clr),
        .o_end_addr  (end_addr),
        .o_full      (full),
        .o_busy      (busy),
        .o_SRAM_ADDR (sram_addr),
        .io_SRAM_DQ  (dq),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives DQ during an output-enabled read, stores on write strobe.
    // The probe driver checks that the DUT has released the bus.
    assign dq = probe_en ? PROBE :
                (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 'z;

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[7:0]] <= dq;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic probe_released(output logic ok);
        probe_en = 1'b1;
        #1;
        ok = (dq === PROBE);
        probe_en = 1'b0;
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d, input bit clr_at_ack,
                            output int ack_cyc, output int we_low, output int ce_low,
                            output logic [15:0] dq_at_ack, output logic released);
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        ack_cyc = -1; we_low = 0; ce_low = 0; dq_at_ack = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!we_n) we_low++;
            if (!ce_n && !lb_n && !ub_n) ce_low++;
            if (bus.wr_ack) begin
                ack_cyc = c;
                dq_at_ack = dq;
                if (clr_at_ack) clr = 1'b1;
                break;
            end
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        probe_released(released);
    endtask

    task automatic do_read(input logic [19:0] a, output int ack_cyc, output int oe_low,
                           output int we_low, output logic [15:0] data);
        @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_addr = a;
        ack_cyc = -1; oe_low = 0; we_low = 0; data = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!oe_n) oe_low++;
            if (!we_n) we_low++;
            if (bus.rd_ack) begin
                ack_cyc = c;
                data = bus.rd_data;
                break;
            end
        end
        bus.rd_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int ack_cyc, we_low, ce_low, oe_low, n_acks, overlap;
        logic [15:0] dqa, rdata;
        logic rel;
        logic [9:0] order;

        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_we_n", we_n, 1);
        check_val("rst_ce_n", ce_n, 1);
        check_val("rst_oe_n", oe_n, 1);
        check_val("rst_lb_ub", {lb_n, ub_n}, 2'b11);
        check_val("rst_acks", {bus.wr_ack, bus.rd_ack}, 0);
        check_val("rst_rd_data", bus.rd_data, 0);
        check_val("rst_end_full_busy", {end_addr, full, busy}, 0);
        check_val("rst_addr", sram_addr, 0);
        probe_released(rel);
        check_val("rst_dq_z", rel, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write
        do_write(20'h00010, 16'hBEEF, 0, ack_cyc, we_low, ce_low, dqa, rel);
        check_val("wr_ack_latency", ack_cyc, 3);
        check_val("wr_we_low", we_low, 2);
        check_val("wr_ce_lb_ub_low", ce_low, 3);
        check_val("wr_dq_hold", dqa, 16'hBEEF);
        check_val("wr_dq_z_after", rel, 1);
        check_val("wr_end_addr", end_addr, 20'h00011);
        check_val("wr_busy_after", busy, 0);
        check_val("wr_mem", mem[8'h10], 16'hBEEF);

        // Single read
        do_read(20'h00010, ack_cyc, oe_low, we_low, rdata);
        check_val("rd_ack_latency", ack_cyc, 3);
        check_val("rd_oe_low", oe_low, 2);
        check_val("rd_we_low", we_low, 0);
        check_val("rd_data", rdata, 16'hBEEF);
        check_val("rd_data_held", bus.rd_data, 16'hBEEF);
        check_val("rd_oe_after", oe_n, 1);

        // end_addr does not shrink
        do_write(20'h000FF, 16'h1234, 0, ack_cyc, we_low, ce_low, dqa, rel);
        check_val("end_addr_100", end_addr, 20'h00100);
        do_write(20'h00005, 16'h5555, 0, ack_cyc, we_low, ce_low, dqa, rel);
        check_val("end_addr_keep", end_addr, 20'h00100);

        // Top address saturates and sets full; clear coinciding with next ack wins
        do_write(20'hFFFFF, 16'hCAFE, 0, ack_cyc, we_low, ce_low, dqa, rel);
        check_val("full_set", full, 1);
        check_val("end_addr_sat", end_addr, 20'hFFFFF);
        do_write(20'h00020, 16'h0BAD, 1, ack_cyc, we_low, ce_low, dqa, rel);
        check_val("clr_ack_latency", ack_cyc, 3);
        check_val("clr_end_full", {end_addr, full}, 0);
        check_val("clr_mem", mem[8'h20], 16'h0BAD);
        do_write(20'h00007, 16'h7777, 0, ack_cyc, we_low, ce_low, dqa, rel);
        check_val("end_addr_resume", end_addr, 20'h00008);

        // Both requests held: four writes per read, no overlapping acks
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = 20'h00040; bus.wr_data = 16'h1111;
        bus.rd_req = 1'b1; bus.rd_addr = 20'h00010;
        order = '0; n_acks = 0; overlap = 0;
        for (int c = 0; c < 200 && n_acks < 10; c++) begin
            @(negedge clk);
            if (bus.wr_ack && bus.rd_ack) overlap++;
            if (bus.wr_ack) begin
                order[9 - n_acks] = 1'b1;
                n_acks++;
            end else if (bus.rd_ack) begin
                order[9 - n_acks] = 1'b0;
                n_acks++;
            end
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        check_val("arb_ack_count", n_acks, 10);
        check_val("arb_order", order, 10'b1111011110);
        check_val("arb_overlap", overlap, 0);
        check_val("arb_rd_data", bus.rd_data, 16'hBEEF);
        repeat (4) @(negedge clk);
        check_val("arb_end_addr", end_addr, 20'h00041);
        check_val("arb_idle", busy, 0);

        // Reset during write pulse aborts; pending write is re-granted afterwards
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = 20'h00030; bus.wr_data = 16'hA5A5;
        @(negedge clk);
        check_val("abort_we_pre", we_n, 0);
        rst_n = 1'b0;
        #1;
        check_val("abort_we_n", we_n, 1);
        check_val("abort_ce_n", ce_n, 1);
        check_val("abort_busy", busy, 0);
        probe_released(rel);
        check_val("abort_dq_z", rel, 1);
        @(negedge clk);
        check_val("abort_no_ack", bus.wr_ack, 0);
        rst_n = 1'b1;
        ack_cyc = -1; dqa = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.wr_ack) begin
                ack_cyc = c;
                dqa = dq;
                break;
            end
        end
        bus.wr_req = 1'b0;
        check_val("regrant_latency", ack_cyc, 3);
        check_val("regrant_dq", dqa, 16'hA5A5);
        repeat (2) @(negedge clk);
        check_val("regrant_end_addr", end_addr, 20'h00031);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
